// File: rtl/imm_ext_stage.sv
// imm_ext_stage
// -----------------------------------------------------------------------------
// Buffered immediate-extension stage sitting between instruction fetch and
// decode. Each accepted 16-bit instruction has its immediate field extracted,
// sign- or zero-extended to OUT_W bits, and optionally pre-shifted left by one
// for branch offsets. The result is stored, with its sideband tag and an error
// flag, in a 2-entry skid buffer. The buffer has valid/ready handshakes on both
// sides and a synchronous flush.
//
// Parameters
//   OUT_W  width of the extended immediate (>= 16)
//   TAG_W  width of the sideband tag carried with each entry
//
// Ports
//   clk        clock, rising-edge active
//   rst        synchronous active-high reset
//   flush      drop every buffered entry and any same-cycle input
//   in_valid   upstream offers an instruction
//   in_ready   stage can accept this cycle (registered state and rst only)
//   in_instr   16-bit instruction word
//   in_mode    extension mode (0..6 defined, 7 reserved)
//   in_tag     sideband tag, passed through unchanged
//   out_valid  head entry valid
//   out_ready  consumer takes the head entry this cycle
//   out_imm    extended immediate of the head entry (0 when idle)
//   out_tag    tag of the head entry (0 when idle)
//   out_err    head entry used the reserved mode (0 when idle)
// -----------------------------------------------------------------------------
module imm_ext_stage #(
  parameter int OUT_W = 16,
  parameter int TAG_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_instr,
  input  logic [2:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  typedef enum logic [2:0] {
    MODE_Z5   = 3'd0,  // zero-extend instr[4:0]
    MODE_S5   = 3'd1,  // sign-extend instr[4:0]
    MODE_Z8   = 3'd2,  // zero-extend instr[7:0]
    MODE_S8   = 3'd3,  // sign-extend instr[7:0]
    MODE_S11  = 3'd4,  // sign-extend instr[10:0]
    MODE_B8   = 3'd5,  // sign-extend instr[7:0], then << 1
    MODE_B11  = 3'd6,  // sign-extend instr[10:0], then << 1
    MODE_RSVD = 3'd7   // reserved: imm = 0, err = 1
  } mode_e;

  // ---------------------------------------------------------------------------
  // Combinational extension of the incoming instruction
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] ext_imm;
  logic             ext_err;

  // NOTE: every output of an always_comb gets a default first, so no path
  // through the case can leave a value held and infer a latch.
  always_comb begin
    ext_imm = '0;
    ext_err = 1'b0;
    unique case (mode_e'(in_mode))
      MODE_Z5:   ext_imm = {{(OUT_W-5){1'b0}},         in_instr[4:0]};
      MODE_S5:   ext_imm = {{(OUT_W-5){in_instr[4]}},  in_instr[4:0]};
      MODE_Z8:   ext_imm = {{(OUT_W-8){1'b0}},         in_instr[7:0]};
      MODE_S8:   ext_imm = {{(OUT_W-8){in_instr[7]}},  in_instr[7:0]};
      MODE_S11:  ext_imm = {{(OUT_W-11){in_instr[10]}}, in_instr[10:0]};
      // Branch forms: extend to OUT_W-1 bits and append a zero LSB, which is
      // the one-bit left shift with no overflow since OUT_W >= 16.
      MODE_B8:   ext_imm = {{(OUT_W-9){in_instr[7]}},   in_instr[7:0],  1'b0};
      MODE_B11:  ext_imm = {{(OUT_W-12){in_instr[10]}}, in_instr[10:0], 1'b0};
      MODE_RSVD: ext_err = 1'b1;
      default:   ext_err = 1'b1;
    endcase
  end

  // The top five instruction bits carry no immediate in any mode.
  logic unused_instr_hi;
  assign unused_instr_hi = ^in_instr[15:11];

  // ---------------------------------------------------------------------------
  // Two-entry skid buffer
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] imm_q [2];
  logic [TAG_W-1:0] tag_q [2];
  logic             err_q [2];

  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [1:0]       count_q, count_d;

  logic             push;
  logic             pop;

  // Ready looks only at registered occupancy and rst, so there is no
  // combinational path from out_ready back to in_ready.
  assign in_ready  = !rst && (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);

  // Flush dominates both handshakes.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = ~tail_q;
    if (pop)  head_d = ~head_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: the payload storage is deliberately not reset; an entry is only
  // ever read while count marks it valid, and the outputs are forced to zero
  // otherwise.
  always_ff @(posedge clk) begin
    if (push) begin
      imm_q[tail_q] <= ext_imm;
      tag_q[tail_q] <= in_tag;
      err_q[tail_q] <= ext_err;
    end
  end

  assign out_imm = out_valid ? imm_q[head_q] : '0;
  assign out_tag = out_valid ? tag_q[head_q] : '0;
  assign out_err = out_valid ? err_q[head_q] : 1'b0;

endmodule

// File: tb/tb_imm_ext_stage.sv
// tb_imm_ext_stage
// -----------------------------------------------------------------------------
// Self-checking bench for imm_ext_stage. A 16-bit instance is driven by
// directed sequences and random traffic and compared every cycle against a
// queue-based reference model; a 32-bit instance covers the wide extension.
// -----------------------------------------------------------------------------
module tb_imm_ext_stage;

  typedef struct {
    logic [15:0] imm;
    logic [15:0] tag;
    logic        err;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [2:0]  in_mode;
  logic [15:0] in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_imm;
  logic [15:0] out_tag;
  logic        out_err;

  logic        in_valid32;
  logic        in_ready32;
  logic [15:0] in_instr32;
  logic [2:0]  in_mode32;
  logic        out_valid32;
  logic [31:0] out_imm32;
  logic [15:0] out_tag32;
  logic        out_err32;

  int tests = 0;
  int fails = 0;

  ent_t model_q[$];

  always #5 clk = ~clk;

  imm_ext_stage #(.OUT_W(16), .TAG_W(16)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_tag   (out_tag),
    .out_err   (out_err)
  );

  imm_ext_stage #(.OUT_W(32), .TAG_W(16)) u_dut32 (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .in_valid  (in_valid32),
    .in_ready  (in_ready32),
    .in_instr  (in_instr32),
    .in_mode   (in_mode32),
    .in_tag    (16'h0032),
    .out_valid (out_valid32),
    .out_ready (1'b1),
    .out_imm   (out_imm32),
    .out_tag   (out_tag32),
    .out_err   (out_err32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference extension from the mode table using plain integer arithmetic:
  // take the field value, make it negative if its top bit is set (signed
  // modes), double it for branch modes, then reduce modulo 2**w.
  function automatic longint unsigned ref_imm(input int instr, input int mode, input int w);
    longint v;
    case (mode)
      0: v = instr % 32;
      1: begin v = instr % 32;   if (v >= 16)   v -= 32;   end
      2: v = instr % 256;
      3: begin v = instr % 256;  if (v >= 128)  v -= 256;  end
      4: begin v = instr % 2048; if (v >= 1024) v -= 2048; end
      5: begin v = instr % 256;  if (v >= 128)  v -= 256;  v = v * 2; end
      6: begin v = instr % 2048; if (v >= 1024) v -= 2048; v = v * 2; end
      default: v = 0;
    endcase
    return longint'(v) & ((longint'(1) << w) - 1);
  endfunction

  // One clock of the 16-bit instance: drive inputs, compare outputs against
  // the model half a cycle later, then advance the model across the edge.
  task automatic step(input logic v, input logic [15:0] instr, input logic [2:0] mode,
                      input logic [15:0] tag, input logic ordy, input logic fl, input logic r);
    logic m_ready, m_push, m_pop;
    ent_t e;
    in_valid  = v;
    in_instr  = instr;
    in_mode   = mode;
    in_tag    = tag;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    @(negedge clk);
    m_ready = !r && (model_q.size() < 2);
    m_push  = v && m_ready && !fl;
    m_pop   = (model_q.size() != 0) && ordy && !fl;
    check("in_ready",  {63'd0, in_ready},  {63'd0, m_ready});
    check("out_valid", {63'd0, out_valid}, {63'd0, model_q.size() != 0});
    if (model_q.size() != 0) begin
      check("out_imm", {48'd0, out_imm}, {48'd0, model_q[0].imm});
      check("out_tag", {48'd0, out_tag}, {48'd0, model_q[0].tag});
      check("out_err", {63'd0, out_err}, {63'd0, model_q[0].err});
    end else begin
      check("idle_imm", {48'd0, out_imm}, 64'd0);
      check("idle_tag", {48'd0, out_tag}, 64'd0);
      check("idle_err", {63'd0, out_err}, 64'd0);
    end
    e.imm = 16'(ref_imm(int'(instr), int'(mode), 16));
    e.tag = tag;
    e.err = (mode == 3'd7);
    @(posedge clk);
    if (r || fl) begin
      model_q.delete();
    end else begin
      if (m_pop)  void'(model_q.pop_front());
      if (m_push) model_q.push_back(e);
    end
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 16'h0000, 3'd0, 16'h0000, ordy, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [15:0] instr;
    logic [2:0]  mode;
    logic [15:0] imm;
    logic        err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{16'h001F, 3'd0, 16'h001F, 1'b0};
    vecs[1] = '{16'h001F, 3'd1, 16'hFFFF, 1'b0};
    vecs[2] = '{16'h0080, 3'd2, 16'h0080, 1'b0};
    vecs[3] = '{16'h0080, 3'd3, 16'hFF80, 1'b0};
    vecs[4] = '{16'h0400, 3'd4, 16'hFC00, 1'b0};
    vecs[5] = '{16'h0400, 3'd6, 16'hF800, 1'b0};
    vecs[6] = '{16'h00FF, 3'd5, 16'hFFFE, 1'b0};
    vecs[7] = '{16'h1234, 3'd7, 16'h0000, 1'b1};
    vecs[8] = '{16'h000F, 3'd1, 16'h000F, 1'b0};

    rst        = 1'b1;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_instr   = '0;
    in_mode    = '0;
    in_tag     = '0;
    out_ready  = 1'b0;
    in_valid32 = 1'b0;
    in_instr32 = '0;
    in_mode32  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready_low", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {63'd0, in_ready}, 64'd1);
    check("post_rst_valid", {63'd0, out_valid}, 64'd0);

    // Every mode, one per cycle; each result is head right after its push.
    for (int i = 0; i < 9; i++) begin
      step(1'b1, vecs[i].instr, vecs[i].mode, 16'(16'h0200 + i), 1'b1, 1'b0, 1'b0);
      check("mode_imm",   {48'd0, out_imm},   {48'd0, vecs[i].imm});
      check("mode_err",   {63'd0, out_err},   {63'd0, vecs[i].err});
      check("mode_valid", {63'd0, out_valid}, 64'd1);
    end
    idle(1'b1);

    // Backpressure: only two entries absorbed while out_ready is low.
    step(1'b1, 16'h0001, 3'd0, 16'h0100, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0002, 3'd0, 16'h0102, 1'b0, 1'b0, 1'b0);
    check("bp_ready_low", {63'd0, in_ready}, 64'd0);
    step(1'b1, 16'h0003, 3'd0, 16'h0104, 1'b0, 1'b0, 1'b0);
    check("bp_head_0100", {48'd0, out_tag}, 64'h0100);
    step(1'b1, 16'h0003, 3'd0, 16'h0104, 1'b1, 1'b0, 1'b0);
    check("bp_head_0102", {48'd0, out_tag}, 64'h0102);
    step(1'b1, 16'h0003, 3'd0, 16'h0104, 1'b1, 1'b0, 1'b0);
    check("bp_head_0104", {48'd0, out_tag}, 64'h0104);
    idle(1'b1);
    check("bp_drained", {63'd0, out_valid}, 64'd0);

    // Streaming at count=1: ten back-to-back, no bubbles.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 16'(i * 37), 3'(i % 7), 16'(16'h0300 + i), 1'b1, 1'b0, 1'b0);
      check("stream_valid", {63'd0, out_valid}, 64'd1);
      check("stream_tag",   {48'd0, out_tag},   {48'd0, 16'(16'h0300 + i)});
    end
    idle(1'b1);

    // Flush with two buffered entries and a valid input in the same cycle.
    step(1'b1, 16'h0011, 3'd2, 16'h0400, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0022, 3'd2, 16'h0401, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0033, 3'd2, 16'h0402, 1'b1, 1'b1, 1'b0);
    check("flush_valid", {63'd0, out_valid}, 64'd0);
    check("flush_ready", {63'd0, in_ready},  64'd1);
    // Flush at count=1 where the same-cycle input would otherwise be taken.
    step(1'b1, 16'h0044, 3'd2, 16'h0403, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0055, 3'd2, 16'hDEAD, 1'b0, 1'b1, 1'b0);
    check("flush_drop_valid", {63'd0, out_valid}, 64'd0);
    idle(1'b1);
    check("flush_drop_stays", {63'd0, out_valid}, 64'd0);

    // Reset mid-stream with two entries buffered.
    step(1'b1, 16'h0066, 3'd3, 16'h0500, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0077, 3'd3, 16'h0501, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0088, 3'd3, 16'h0502, 1'b1, 1'b0, 1'b1);
    check("rst_mid_valid", {63'd0, out_valid}, 64'd0);
    check("rst_mid_imm",   {48'd0, out_imm},   64'd0);
    check("rst_mid_tag",   {48'd0, out_tag},   64'd0);
    check("rst_mid_err",   {63'd0, out_err},   64'd0);
    idle(1'b0);
    check("rst_mid_empty", {63'd0, out_valid}, 64'd0);

    // Wide instance.
    in_valid32 = 1'b1;
    in_instr32 = 16'h0400;
    in_mode32  = 3'd6;
    idle(1'b1);
    check("w32_b11_imm",   {32'd0, out_imm32},   64'hFFFF_F800);
    check("w32_b11_valid", {63'd0, out_valid32}, 64'd1);
    in_instr32 = 16'h0080;
    in_mode32  = 3'd2;
    idle(1'b1);
    check("w32_z8_imm", {32'd0, out_imm32}, 64'h0000_0080);
    in_valid32 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      logic [15:0] ri;
      logic [2:0]  rm;
      ri = 16'($urandom);
      rm = 3'($urandom_range(0, 7));
      in_valid32 = 1'b1;
      in_instr32 = ri;
      in_mode32  = rm;
      idle(1'b1);
      check("w32_rand_imm", {32'd0, out_imm32}, ref_imm(int'(ri), int'(rm), 32));
      check("w32_rand_err", {63'd0, out_err32}, {63'd0, rm == 3'd7});
    end
    in_valid32 = 1'b0;
    idle(1'b1);

    // Random traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), 16'($urandom), 3'($urandom_range(0, 7)),
           16'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 79) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
